// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: address sizing and status bundle.
package sync_fifo_pkg;

  // Address width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// error flags, synchronous flush and selectable registered / first-word-fall-through read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   w_en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             full_c, empty_c;
  logic             wr_ok_c, rd_ok_c;
  logic [WIDTH-1:0] rdata_c;
  fifo_status_t     status_c;

  // Extra pointer MSB separates a wrapped (full) pointer pair from an equal (empty) one.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}});

  assign wr_ok_c = w_en & ~full_c & ~flush;
  assign rd_ok_c = r_en & ~empty_c & ~flush;

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok_c),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rdata_c)
  );

  // Next-state for pointers, occupancy and sticky error flags; flush overrides requests.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_ok_c, rd_ok_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (w_en & full_c);
      unf_d = unf_q | (r_en & empty_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    status_c.full         = full_c;
    status_c.empty        = empty_c;
    status_c.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    status_c.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    status_c.overflow     = ovf_q;
    status_c.underflow    = unf_q;
  end

  assign full         = status_c.full;
  assign empty        = status_c.empty;
  assign almost_full  = status_c.almost_full;
  assign almost_empty = status_c.almost_empty;
  assign overflow     = status_c.overflow;
  assign underflow    = status_c.underflow;
  assign count        = count_q;

  // Read side: head word presented directly, or captured into a register on each pop.
  if (FWFT != 0) begin : g_fwft
    assign data_out = rdata_c;
    assign rd_valid = ~empty_c;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
      dout_d   = dout_q;
      rvalid_d = rd_ok_c;
      if (rd_ok_c) dout_d = rdata_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q   <= '0;
        rvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rvalid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read and a FWFT instance share one stimulus
// stream and are checked every cycle against a queue model, plus directed literal checks.
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  localparam int unsigned D  = 8;
  localparam int unsigned AF = 6;
  localparam int unsigned AE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout0, dout1;
  logic       rv0, rv1, full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [3:0] cnt0, cnt1;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout0), .rd_valid(rv0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout1), .rd_valid(rv1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  // Behavioural model: contents as a queue, plus flags and last popped word.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_rv = 1'b0;
  logic [7:0] m_dout = 8'h00;

  int  n_chk = 0;
  int  n_pass = 0;
  bit  run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic fifo_status_t model_status();
    fifo_status_t s;
    int n = mq.size();
    s.full         = (n == D);
    s.empty        = (n == 0);
    s.almost_full  = (n >= AF);
    s.almost_empty = (n <= AE);
    s.overflow     = m_ovf;
    s.underflow    = m_unf;
    return s;
  endfunction

  // Apply the rules to the pre-edge model state and the current request inputs.
  task automatic model_step();
    int n = mq.size();
    bit wr, rd;
    if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      wr = w_en && (n < D);
      rd = r_en && (n > 0);
      if (w_en && n == D) m_ovf = 1'b1;
      if (r_en && n == 0) m_unf = 1'b1;
      m_rv = rd;
      if (rd) m_dout = mq.pop_front();
      if (wr) mq.push_back(data_in);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_rv   = 1'b0;
    m_dout = 8'h00;
  endtask

  // One cycle: drive at the falling edge, update the model at the rising edge.
  task automatic op(input logic w, input logic [7:0] d, input logic r, input logic f);
    w_en = w; data_in = d; r_en = r; flush = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (run && rst_n) begin
      fifo_status_t s0, s1, sm;
      sm = model_status();
      s0 = '{full0, empty0, af0, ae0, ovf0, unf0};
      s1 = '{full1, empty1, af1, ae1, ovf1, unf1};
      chk("status_reg", 32'(s0), 32'(sm));
      chk("count_reg", cnt0, mq.size());
      chk("rdvalid_reg", rv0, m_rv);
      chk("dout_reg", dout0, m_dout);
      chk("status_fwft", 32'(s1), 32'(sm));
      chk("count_fwft", cnt1, mq.size());
      chk("rdvalid_fwft", rv1, mq.size() != 0);
      if (mq.size() != 0) chk("dout_fwft", dout1, mq[0]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_rv", rv0, 0);
    rst_n = 1'b1;
    run = 1'b1;
    @(negedge clk);

    // Fill and drain
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 5) chk("af_at5", af0, 0);
      if (i == 6) chk("af_at6", af0, 1);
    end
    chk("fill_full", full0, 1);
    chk("fill_count", cnt0, 8);
    op(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_count", cnt0, 8);
    chk("ovf_flag", ovf0, 1);
    for (int i = 1; i <= 8; i++) begin
      op(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_dout", dout0, i);
      chk("drain_rv", rv0, 1);
    end
    op(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_rv", rv0, 0);
    chk("idle_hold", dout0, 8'h08);
    chk("drain_empty", empty0, 1);
    chk("drain_ae", ae0, 1);

    // Underflow, stickiness, flush
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_flag", unf0, 1);
    op(1'b0, 8'h00, 1'b0, 1'b0);
    chk("unf_sticky", unf0, 1);
    chk("ovf_sticky", ovf0, 1);
    op(1'b1, 8'h55, 1'b1, 1'b1);
    chk("flush_ovf", ovf0, 0);
    chk("flush_unf", unf0, 0);
    chk("flush_count", cnt0, 0);
    chk("flush_dout_hold", dout0, 8'h08);

    // Simultaneous read/write at count 4 with pointer wrap
    for (int i = 0; i < 4; i++) op(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      op(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
      chk("rw_count", cnt0, 4);
      chk("rw_dout", dout0, (i < 4) ? (8'h10 + i) : (8'h20 + i - 4));
    end

    // Full with both requests: read accepted, write dropped
    for (int i = 0; i < 4; i++) op(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("full_again", full0, 1);
    op(1'b1, 8'hBB, 1'b1, 1'b0);
    chk("fullrw_count", cnt0, 7);
    chk("fullrw_ovf", ovf0, 1);
    chk("fullrw_dout", dout0, 8'h26);

    // Empty with both requests: write accepted, read dropped
    for (int i = 0; i < 7; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    op(1'b1, 8'h77, 1'b1, 1'b0);
    chk("emptyrw_count", cnt0, 1);
    chk("emptyrw_unf", unf0, 1);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("emptyrw_dout", dout0, 8'h77);

    // FWFT presentation
    op(1'b0, 8'h00, 1'b0, 1'b1);
    op(1'b1, 8'h11, 1'b0, 1'b0);
    chk("fwft_first", dout1, 8'h11);
    chk("fwft_rv", rv1, 1);
    op(1'b1, 8'h22, 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_second", dout1, 8'h22);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_empty", empty1, 1);
    chk("fwft_rv_low", rv1, 0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) op(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("pre_rst_count", cnt0, 5);
    w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_count", cnt0, 0);
    chk("mid_rst_empty", empty0, 1);
    chk("mid_rst_ae", ae0, 1);
    chk("mid_rst_dout", dout0, 0);
    chk("mid_rst_rv", rv0, 0);
    chk("mid_rst_fwft_rv", rv1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    op(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("post_rst_fwft", dout1, 8'h5A);
    chk("post_rst_count", cnt0, 1);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_dout", dout0, 8'h5A);
    chk("post_rst_empty", empty0, 1);

    // Randomized traffic in write-heavy, read-heavy and balanced phases
    for (int k = 0; k < 3000; k++) begin
      int unsigned wp, rp;
      logic w, r, f;
      case ((k / 500) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 50; rp = 50; end
      endcase
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < rp);
      f = ($urandom_range(0, 127) == 0);
      op(w, 8'($urandom), r, f);
    end

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO. Next generation of the team's synchronous FIFO.
- Adds configurable width and depth, occupancy count, almost-full and almost-empty thresholds, and sticky overflow/underflow error flags.
- Adds a synchronous flush and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain; used directly by the layered testbench environment.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 16: number of entries; power of 2, >=2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH (range 1..DEPTH).
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH (range 0..DEPTH-1).
- FWFT, 0: 0 = registered read (1-cycle latency); 1 = head word visible on data_out whenever not empty.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous clear of pointers, count and error flags.
- w_en  in  1  write request.
- data_in  in  WIDTH  write data.
- r_en  in  1  read request (pop).
- data_out  out  WIDTH  read data.
- rd_valid  out  1  data_out holds a newly popped word (FWFT=0); equals !empty (FWFT=1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset values (async assert, sync deassert at the next clk edge):
  - Pointers = 0, count = 0, empty = 1, full = 0.
  - almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0.
  - rd_valid = 0, data_out = 0.
  - Memory contents are not reset.
- Pointers are ADDR_W+1 bits (ADDR_W = $clog2(DEPTH)). The extra MSB distinguishes full from empty. Addresses wrap naturally from DEPTH-1 to 0.
- Accept rules:
  - wr_ok = w_en & !full.
  - rd_ok = r_en & !empty.
  - Both are evaluated on pre-edge state. There is no bypass: a word written while empty is readable in the next cycle at the earliest.
- Simultaneous operations:
  - wr_ok and rd_ok together: both pointers advance, count unchanged.
  - Full with w_en and r_en: read accepted, write dropped, overflow set.
  - Empty with w_en and r_en: write accepted, read dropped, underflow set.
- Count update: +1 on wr_ok only, -1 on rd_ok only, otherwise held. full, empty, almost_* and count are all registered or derived from registered count, so they are valid in the cycle after the edge.
- FWFT=0:
  - data_out is loaded with mem[rd_ptr] on rd_ok, and rd_valid pulses 1 for exactly that following cycle.
  - data_out holds its value otherwise.
- FWFT=1:
  - data_out = mem[rd_ptr] whenever !empty; rd_valid = !empty.
  - r_en with !empty pops, and the next word appears the cycle after.
  - data_out is don't-care when empty; the bench must not check it.
- Error flags: overflow and underflow are sticky once set. Only rst_n or flush clears them.
- flush:
  - Takes priority over w_en and r_en in the same cycle; any request that cycle is ignored and does not set the error flags.
  - Returns every output to its reset value except data_out, which holds.
- Reset mid-operation: all state clears immediately. Words held before reset are lost and must never be presented afterwards.

Decomposition:
- Package sync_fifo_pkg holds:
  - the function computing ADDR_W from DEPTH;
  - a typedef struct for the status bundle (full, empty, almost_full, almost_empty, overflow, underflow) used by the monitor and scoreboard.
- One sub-module, fifo_mem: a simple dual-port register array (one write port, one asynchronous read port, WIDTH x DEPTH).
- The controller (pointers, count, flags, read register) stays in sync_fifo_param.

Test Plan (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1, FWFT=0 unless noted):
- Fill and drain: write 0x01..0x08 on consecutive cycles.
  - After the 6th write: almost_full=1. After the 8th: full=1, count=8.
  - Then read 8 times: data_out = 0x01..0x08 one cycle after each r_en, rd_valid pulsing each time.
  - At the end: empty=1, almost_empty=1.
- Overflow/underflow: with full, assert w_en with 0xAA → count stays 8 and overflow=1. Drain to empty, then r_en → underflow=1. Both flags stay 1 until flush, which clears them and leaves count=0.
- Simultaneous operations:
  - At count=4, w_en+r_en for 10 cycles → count stays 4, pointer wrap exercised, data order preserved.
  - When full, w_en+r_en → count=7, overflow=1.
  - When empty, w_en+r_en → count=1, underflow=1.
- FWFT=1: write 0x11, 0x22 → data_out=0x11 with rd_valid=1 the cycle after the first write. After r_en: data_out=0x22. After a second r_en: empty=1, rd_valid=0.
- Reset mid-operation: at count=5, pulse rst_n low between edges → outputs return to reset values immediately. A subsequent write of 0x5A then read returns 0x5A with no stale data.
